branch_address_unit: RTL and testbench

- Parametrised, registered successor to the combinational address builder in the RV32I core.
- Computes the effective address for JAL, JALR, branch, load and store instructions, and resolves branch conditions.
- Adds link-address generation, misalignment detection, a valid/ready pipeline stage with flush, and a saturating taken-branch counter.
- Sits between decode/register-read and the fetch redirect / LSU address paths.

---
 rtl/branch_address_unit_pkg.sv | 43 ++++
 rtl/branch_address_unit_if.sv | 51 +++++
 rtl/branch_address_unit_cmp.sv | 36 +++
 rtl/branch_address_unit.sv | 132 +++++++++++++
 tb/tb_branch_address_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_address_unit_pkg.sv
// Shared constants for the branch/address unit: instruction type codes,
// branch flag encodings, branch-condition funct3 encodings and a helper
// that maps an instruction class to its branch flag.
package branch_address_unit_pkg;

    // Instruction type codes as presented by decode
    localparam logic [2:0] R_TYPE = 3'd0;
    localparam logic [2:0] I_TYPE = 3'd1;
    localparam logic [2:0] S_TYPE = 3'd2;
    localparam logic [2:0] B_TYPE = 3'd3;
    localparam logic [2:0] U_TYPE = 3'd4;
    localparam logic [2:0] J_TYPE = 3'd5;

    // Branch flag reported alongside the target
    localparam logic [1:0] FLAG_NONE = 2'b00;
    localparam logic [1:0] FLAG_JAL  = 2'b01;
    localparam logic [1:0] FLAG_JALR = 2'b10;
    localparam logic [1:0] FLAG_BR   = 2'b11;

    // Branch condition encodings (RISC-V funct3)
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Branch flag for an instruction class; loads, stores and everything
    // else that does not redirect report FLAG_NONE.
    function automatic logic [1:0] flag_for(input logic [2:0] instr_type,
                                            input logic       is_jalr);
        logic [1:0] flag;
        flag = FLAG_NONE;
        case (instr_type)
            J_TYPE:  flag = FLAG_JAL;
            I_TYPE:  flag = is_jalr ? FLAG_JALR : FLAG_NONE;
            B_TYPE:  flag = FLAG_BR;
            default: flag = FLAG_NONE;
        endcase
        return flag;
    endfunction

endpackage

// File: rtl/branch_address_unit_if.sv
// Bus between decode/register-read, the branch/address unit and its
// consumer (fetch redirect / LSU address path).
//
// Handshake: the input side transfers when in_valid && in_ready at a clk
// edge (and flush is low); the output side transfers when
// out_valid && out_ready at a clk edge. While out_valid is high and
// out_ready is low every result signal stays stable. flush drops both the
// held result and any input offered in the same cycle.
interface branch_address_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // Input side
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       instr_type;
    logic             is_jalr;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  imm;
    logic             flush;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  address_target;
    logic [XLEN-1:0]  link_addr;
    logic [1:0]       flag_branch;
    logic             taken;
    logic             misaligned;
    logic [CNT_W-1:0] taken_count;

    // Unit side
    modport slave (
        input  in_valid, instr_type, is_jalr, funct3, pc, rs1, rs2, imm,
               flush, out_ready,
        output in_ready, out_valid, address_target, link_addr, flag_branch,
               taken, misaligned, taken_count
    );

    // Producer/consumer side
    modport master (
        output in_valid, instr_type, is_jalr, funct3, pc, rs1, rs2, imm,
               flush, out_ready,
        input  in_ready, out_valid, address_target, link_addr, flag_branch,
               taken, misaligned, taken_count
    );

endinterface

// File: rtl/branch_address_unit_cmp.sv
// Branch condition evaluator: compares rs1 against rs2 according to the
// RISC-V funct3 encoding. Reserved encodings (010/011) never take.
module branch_cmp
    import branch_address_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [2:0]      funct3_i,
    output logic            cond_o
);

    logic is_eq;
    logic is_lt;
    logic is_ltu;

    assign is_eq  = (rs1_i == rs2_i);
    assign is_lt  = ($signed(rs1_i) < $signed(rs2_i));
    assign is_ltu = (rs1_i < rs2_i);

    // Select the comparison requested by funct3
    always_comb begin
        cond_o = 1'b0;
        case (funct3_i)
            BR_EQ:   cond_o = is_eq;
            BR_NE:   cond_o = !is_eq;
            BR_LT:   cond_o = is_lt;
            BR_GE:   cond_o = !is_lt;
            BR_LTU:  cond_o = is_ltu;
            BR_GEU:  cond_o = !is_ltu;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_address_unit.sv
// Registered branch/address unit: builds the effective address for JAL,
// JALR, branches, loads and stores, resolves branch conditions, produces
// the link address and misalignment flag, and counts taken redirects in a
// saturating counter. One valid/ready pipeline stage with flush.
module branch_address_unit
    import branch_address_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int C_EXT = 0,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_address_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Without compressed instructions a redirect target must be word aligned.
    localparam bit CHECK_WORD_ALIGN = (C_EXT == 0);

    // Next-result values computed from the current inputs
    logic [XLEN-1:0]  sum_rs1;
    logic [XLEN-1:0]  sum_pc;
    logic [XLEN-1:0]  target_d;
    logic [XLEN-1:0]  link_d;
    logic [1:0]       flag_d;
    logic             taken_d;
    logic             misaligned_d;
    logic             branch_cond;

    // Result registers
    logic             out_valid_q;
    logic [XLEN-1:0]  target_q;
    logic [XLEN-1:0]  link_q;
    logic [1:0]       flag_q;
    logic             taken_q;
    logic             misaligned_q;
    logic [CNT_W-1:0] taken_count_q;

    logic             in_ready;
    logic             accept;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_branch_cmp (
        .rs1_i    (bus.rs1),
        .rs2_i    (bus.rs2),
        .funct3_i (bus.funct3),
        .cond_o   (branch_cond)
    );

    assign sum_rs1 = bus.rs1 + bus.imm;
    assign sum_pc  = bus.pc + bus.imm;
    assign link_d  = bus.pc + XLEN'(4);

    // Target and taken selection by instruction class
    always_comb begin
        target_d = '0;
        taken_d  = 1'b0;
        flag_d   = flag_for(bus.instr_type, bus.is_jalr);
        case (bus.instr_type)
            J_TYPE: begin
                target_d = sum_pc;
                taken_d  = 1'b1;
            end
            I_TYPE: begin
                if (bus.is_jalr) begin
                    target_d = {sum_rs1[XLEN-1:1], 1'b0};
                    taken_d  = 1'b1;
                end else begin
                    target_d = sum_rs1;
                end
            end
            S_TYPE: begin
                target_d = sum_rs1;
            end
            B_TYPE: begin
                target_d = sum_pc;
                taken_d  = branch_cond;
            end
            default: begin
                target_d = '0;
                taken_d  = 1'b0;
            end
        endcase
    end

    // A redirect to a non-word-aligned target is still reported as taken;
    // the trap itself is raised further down the pipe.
    assign misaligned_d = taken_d && CHECK_WORD_ALIGN && target_d[1];

    // The stage is free when empty or when its result leaves this cycle.
    assign in_ready = rst_n && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready && !bus.flush;

    // Pipeline register, flush handling and saturating taken counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            target_q      <= '0;
            link_q        <= '0;
            flag_q        <= FLAG_NONE;
            taken_q       <= 1'b0;
            misaligned_q  <= 1'b0;
            taken_count_q <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            target_q     <= target_d;
            link_q       <= link_d;
            flag_q       <= flag_d;
            taken_q      <= taken_d;
            misaligned_q <= misaligned_d;
            if (taken_d && (taken_count_q != CNT_MAX)) begin
                taken_count_q <= taken_count_q + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.address_target = target_q;
    assign bus.link_addr      = link_q;
    assign bus.flag_branch    = flag_q;
    assign bus.taken          = taken_q;
    assign bus.misaligned     = misaligned_q;
    assign bus.taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_address_unit.sv
// Bench for branch_address_unit: two instances share one stimulus stream,
// one word-aligned with a 16-bit counter, one compressed with a 2-bit
// counter. A queue-based reference model predicts every result.
module tb_branch_address_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Shared stimulus
    logic        in_valid_s;
    logic [2:0]  instr_type_s;
    logic        is_jalr_s;
    logic [2:0]  funct3_s;
    logic [31:0] pc_s;
    logic [31:0] rs1_s;
    logic [31:0] rs2_s;
    logic [31:0] imm_s;
    logic        flush_s;
    logic        out_ready_s;

    branch_address_unit_if #(.XLEN(32), .CNT_W(16)) bus_a ();
    branch_address_unit_if #(.XLEN(32), .CNT_W(2))  bus_b ();

    assign bus_a.in_valid   = in_valid_s;
    assign bus_a.instr_type = instr_type_s;
    assign bus_a.is_jalr    = is_jalr_s;
    assign bus_a.funct3     = funct3_s;
    assign bus_a.pc         = pc_s;
    assign bus_a.rs1        = rs1_s;
    assign bus_a.rs2        = rs2_s;
    assign bus_a.imm        = imm_s;
    assign bus_a.flush      = flush_s;
    assign bus_a.out_ready  = out_ready_s;

    assign bus_b.in_valid   = in_valid_s;
    assign bus_b.instr_type = instr_type_s;
    assign bus_b.is_jalr    = is_jalr_s;
    assign bus_b.funct3     = funct3_s;
    assign bus_b.pc         = pc_s;
    assign bus_b.rs1        = rs1_s;
    assign bus_b.rs2        = rs2_s;
    assign bus_b.imm        = imm_s;
    assign bus_b.flush      = flush_s;
    assign bus_b.out_ready  = out_ready_s;

    branch_address_unit #(.XLEN(32), .C_EXT(0), .CNT_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    branch_address_unit #(.XLEN(32), .C_EXT(1), .CNT_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Scoreboard: {target[68:37], link[36:5], flag[4:3], taken[2], mis_a[1], mis_b[0]}
    logic [68:0] exp_q[$];
    int          cnt_a;
    int          cnt_b;
    bit          exp_zero;
    int          checks;
    int          errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference result straight from the instruction semantics
    function automatic logic [68:0] model(input logic [2:0] ty, input logic jalr,
                                          input logic [2:0] f3, input logic [31:0] pc,
                                          input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic [31:0] imm);
        logic [31:0] t;
        logic [1:0]  f;
        logic        tk;
        t  = 32'h0;
        f  = 2'b00;
        tk = 1'b0;
        if (ty == 3'd5) begin
            t = pc + imm; f = 2'b01; tk = 1'b1;
        end else if (ty == 3'd1 && jalr) begin
            t = (rs1 + imm) & 32'hFFFF_FFFE; f = 2'b10; tk = 1'b1;
        end else if (ty == 3'd1 || ty == 3'd2) begin
            t = rs1 + imm;
        end else if (ty == 3'd3) begin
            t = pc + imm; f = 2'b11;
            case (f3)
                3'b000:  tk = (rs1 == rs2);
                3'b001:  tk = (rs1 != rs2);
                3'b100:  tk = ($signed(rs1) <  $signed(rs2));
                3'b101:  tk = ($signed(rs1) >= $signed(rs2));
                3'b110:  tk = (rs1 <  rs2);
                3'b111:  tk = (rs1 >= rs2);
                default: tk = 1'b0;
            endcase
        end
        return {t, pc + 32'd4, f, tk, tk & t[1], 1'b0};
    endfunction

    // Check all outputs against the model, then advance the model and the clock
    task automatic cycle();
        bit          exp_ready;
        logic [68:0] e;
        #1;
        exp_ready = rst_n && (exp_q.size() == 0 || out_ready_s);
        check("in_ready_a", 64'(bus_a.in_ready), 64'(exp_ready));
        check("in_ready_b", 64'(bus_b.in_ready), 64'(exp_ready));
        check("out_valid_a", 64'(bus_a.out_valid), 64'(exp_q.size() != 0));
        check("out_valid_b", 64'(bus_b.out_valid), 64'(exp_q.size() != 0));
        check("count_a", 64'(bus_a.taken_count), 64'(cnt_a));
        check("count_b", 64'(bus_b.taken_count), 64'(cnt_b));
        if (exp_q.size() != 0 || exp_zero) begin
            e = (exp_q.size() != 0) ? exp_q[0] : 69'h0;
            check("target_a", 64'(bus_a.address_target), 64'(e[68:37]));
            check("target_b", 64'(bus_b.address_target), 64'(e[68:37]));
            check("link_a", 64'(bus_a.link_addr), 64'(e[36:5]));
            check("flag_a", 64'(bus_a.flag_branch), 64'(e[4:3]));
            check("taken_a", 64'(bus_a.taken), 64'(e[2]));
            check("taken_b", 64'(bus_b.taken), 64'(e[2]));
            check("misaligned_a", 64'(bus_a.misaligned), 64'(e[1]));
            check("misaligned_b", 64'(bus_b.misaligned), 64'(e[0]));
        end
        if (!rst_n) begin
            exp_q.delete();
            cnt_a    = 0;
            cnt_b    = 0;
            exp_zero = 1'b1;
        end else if (flush_s) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0 && out_ready_s) void'(exp_q.pop_front());
            if (in_valid_s && exp_ready) begin
                e = model(instr_type_s, is_jalr_s, funct3_s, pc_s, rs1_s, rs2_s, imm_s);
                exp_q.push_back(e);
                exp_zero = 1'b0;
                if (e[2]) begin
                    if (cnt_a < 65535) cnt_a++;
                    if (cnt_b < 3) cnt_b++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] ty, input logic jalr,
                         input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm);
        in_valid_s   = v;
        instr_type_s = ty;
        is_jalr_s    = jalr;
        funct3_s     = f3;
        pc_s         = pc;
        rs1_s        = rs1;
        rs2_s        = rs2;
        imm_s        = imm;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    int          saved_cnt;
    logic [31:0] r;

    initial begin
        checks      = 0;
        errors      = 0;
        cnt_a       = 0;
        cnt_b       = 0;
        exp_zero    = 1'b1;
        rst_n       = 1'b0;
        flush_s     = 1'b0;
        out_ready_s = 1'b1;
        idle();
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // JAL
        drive(1'b1, 3'd5, 1'b0, 3'd0, 32'h100, 32'h0, 32'h0, 32'h20);
        cycle();
        idle();
        check("jal_target", 64'(bus_a.address_target), 64'h120);
        check("jal_link", 64'(bus_a.link_addr), 64'h104);
        check("jal_flag", 64'(bus_a.flag_branch), 64'h1);
        check("jal_taken", 64'(bus_a.taken), 64'h1);
        check("jal_count", 64'(bus_a.taken_count), 64'h1);
        cycle();

        // JALR, aligned then misaligned (word check only on dut_a)
        drive(1'b1, 3'd1, 1'b1, 3'd0, 32'h200, 32'h1003, 32'h0, 32'h2);
        cycle();
        check("jalr_target", 64'(bus_a.address_target), 64'h1004);
        check("jalr_flag", 64'(bus_a.flag_branch), 64'h2);
        drive(1'b1, 3'd1, 1'b1, 3'd0, 32'h204, 32'h1001, 32'h0, 32'h1);
        cycle();
        idle();
        check("jalr_mis_target", 64'(bus_a.address_target), 64'h1002);
        check("jalr_mis_a", 64'(bus_a.misaligned), 64'h1);
        check("jalr_mis_b", 64'(bus_b.misaligned), 64'h0);
        cycle();

        // BLT versus BLTU on the same operands
        drive(1'b1, 3'd3, 1'b0, 3'b100, 32'h300, 32'hFFFF_FFFF, 32'h1, 32'h40);
        cycle();
        check("blt_taken", 64'(bus_a.taken), 64'h1);
        drive(1'b1, 3'd3, 1'b0, 3'b110, 32'h300, 32'hFFFF_FFFF, 32'h1, 32'h40);
        cycle();
        idle();
        check("bltu_taken", 64'(bus_a.taken), 64'h0);
        check("bltu_flag", 64'(bus_a.flag_branch), 64'h3);
        check("bltu_target", 64'(bus_a.address_target), 64'h340);
        cycle();

        // Backpressure with back-to-back inputs
        out_ready_s = 1'b0;
        drive(1'b1, 3'd2, 1'b0, 3'd0, 32'h400, 32'h5000, 32'h0, 32'h8);
        cycle();
        drive(1'b1, 3'd1, 1'b0, 3'd0, 32'h404, 32'h6000, 32'h0, 32'hC);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold_target", 64'(bus_a.address_target), 64'h5008);
            check("bp_in_ready", 64'(bus_a.in_ready), 64'h0);
        end
        out_ready_s = 1'b1;
        cycle();
        idle();
        check("bp_second_target", 64'(bus_a.address_target), 64'h600C);
        cycle();
        check("bp_drained", 64'(bus_a.out_valid), 64'h0);

        // Flush beats a simultaneous taken JAL
        saved_cnt = cnt_a;
        flush_s = 1'b1;
        drive(1'b1, 3'd5, 1'b0, 3'd0, 32'h500, 32'h0, 32'h0, 32'h10);
        cycle();
        flush_s = 1'b0;
        idle();
        check("flush_valid", 64'(bus_a.out_valid), 64'h0);
        check("flush_count", 64'(bus_a.taken_count), 64'(saved_cnt));
        cycle();

        // Five more taken redirects saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd5, 1'b0, 3'd0, 32'h600 + 32'(i * 4), 32'h0, 32'h0, 32'h8);
            cycle();
        end
        check("sat_count_b", 64'(bus_b.taken_count), 64'h3);

        // Reset with a held result clears everything
        out_ready_s = 1'b0;
        drive(1'b1, 3'd5, 1'b0, 3'd0, 32'h700, 32'h0, 32'h0, 32'h4);
        cycle();
        idle();
        rst_n = 1'b0;
        cycle();
        check("rst_valid", 64'(bus_a.out_valid), 64'h0);
        check("rst_target", 64'(bus_a.address_target), 64'h0);
        check("rst_count", 64'(bus_a.taken_count), 64'h0);
        rst_n = 1'b1;
        out_ready_s = 1'b1;
        cycle();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rst_n       = ($urandom_range(0, 149) != 0);
            flush_s     = ($urandom_range(0, 15) == 0);
            out_ready_s = ($urandom_range(0, 9) < 7);
            r = $urandom;
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom,
                  ($urandom_range(0, 1) != 0) ? {{20{r[11]}}, r[11:0]} : r);
            if ($urandom_range(0, 3) == 0) rs2_s = rs1_s;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
